// File: rtl/clk_rate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_rate_ctrl
//
// Runtime-programmable clock-enable generator. Produces a 50%-duty divided
// square wave (clk_out) and a one-cycle enable (tick) at half-periods of
// 1..4 clk cycles (divide by 2, 4, 6 or 8). A new rate is accepted over a
// valid/ready handshake and applied only at the falling edge that ends a full
// clk_out period, or right away while the divider is idle. This way clk_out
// never produces a runt pulse.
//
// Parameters:
//   DEFAULT_SEL  rate selected out of reset (00=/2, 01=/4, 10=/6, 11=/8)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   run        in   1 = divider counts, 0 = divider held idle (clk_out=0)
//   sel_valid  in   rate-change request valid
//   sel_in     in   requested rate, half-period H = sel_in + 1
//   sel_ready  out  request can be accepted (controller idle)
//   done       out  one-cycle pulse: requested rate is now active
//   sel_cur    out  rate currently applied
//   clk_out    out  registered divided square wave, period 2H
//   tick       out  registered pulse coincident with each clk_out 0->1
// ---------------------------------------------------------------------------
module clk_rate_ctrl #(
    parameter logic [1:0] DEFAULT_SEL = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       sel_valid,
    input  logic [1:0] sel_in,
    output logic       sel_ready,
    output logic       done,
    output logic [1:0] sel_cur,
    output logic       clk_out,
    output logic       tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] cnt;       // position inside the current half-period, 0..H-1
    logic [1:0] pend_sel;  // rate captured at acceptance

    logic last_cnt;        // final cycle of the current half-period
    logic boundary;        // this edge applies the pending rate

    // H-1 equals sel_cur itself, so no adder is needed for the compare.
    // A switch lands either on the falling edge that closes a full period
    // or immediately when the divider is idle, since no phase can be cut
    // short in that case.
    always_comb begin
        last_cnt = (cnt == sel_cur);
        boundary = (state == PEND) && (!run || (last_cnt && clk_out));
    end

    // NOTE: all state updates use non-blocking assignments so every branch
    // reads the pre-edge values, which is what the boundary test relies on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            pend_sel  <= DEFAULT_SEL;
            sel_cur   <= DEFAULT_SEL;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            sel_ready <= 1'b1;
            done      <= 1'b0;
        end else begin
            // Divider datapath
            if (boundary) begin
                sel_cur <= pend_sel;
                cnt     <= 2'd0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (!run) begin
                cnt     <= 2'd0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (last_cnt) begin
                cnt     <= 2'd0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;   // high only on the 0->1 toggle
            end else begin
                cnt     <= cnt + 2'd1;
                tick    <= 1'b0;
            end

            // Handshake controller. sel_ready and done are registered
            // alongside the state so they leave the block glitch-free.
            case (state)
                IDLE: begin
                    if (sel_valid && sel_ready) begin
                        pend_sel  <= sel_in;
                        sel_ready <= 1'b0;
                        state     <= PEND;
                    end
                end
                PEND: begin
                    if (boundary) begin
                        done  <= 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    done      <= 1'b0;
                    sel_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    done      <= 1'b0;
                    sel_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_rate_ctrl
//
// Self-checking bench for clk_rate_ctrl. The reference model tracks the
// position inside one full clk_out period (0..2H-1) plus a pending/ack flag
// pair. Every DUT output is compared after every rising edge. Directed
// sequences cover the reset rate, a /2 -> /8 switch, continuous sel_valid,
// run dropped while a request waits and reset asserted mid-request. A long
// randomized run follows.
// ---------------------------------------------------------------------------
module tb_clk_rate_ctrl;

    localparam logic [1:0] DEF = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_in = 2'b00;
    logic       sel_ready;
    logic       done;
    logic [1:0] sel_cur;
    logic       clk_out;
    logic       tick;

    clk_rate_ctrl #(.DEFAULT_SEL(DEF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .sel_valid(sel_valid),
        .sel_in   (sel_in),
        .sel_ready(sel_ready),
        .done     (done),
        .sel_cur  (sel_cur),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int edge_no = 0;

    // Reference model state
    int m_pos;    // edges into the current full period, 0..2H-1
    int m_cur;    // rate in force
    int m_pval;   // rate waiting to be applied
    bit m_pend;   // a request is waiting for its boundary
    bit m_ack;    // done cycle
    bit m_tick;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, edge_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = 0;
        m_cur  = DEF;
        m_pval = DEF;
        m_pend = 0;
        m_ack  = 0;
        m_tick = 0;
    endtask

    task automatic model_edge();
        int h;
        bit accept;
        bit bnd;
        h      = m_cur + 1;
        accept = !m_pend && !m_ack && sel_valid;
        bnd    = m_pend && (!run || m_pos == 2 * h - 1);
        if (bnd) begin
            m_cur  = m_pval;
            m_pos  = 0;
            m_tick = 0;
        end else if (!run) begin
            m_pos  = 0;
            m_tick = 0;
        end else begin
            m_pos  = (m_pos + 1) % (2 * h);
            m_tick = (m_pos == h);
        end
        m_ack = bnd;
        if (accept) begin
            m_pend = 1;
            m_pval = int'(sel_in);
        end else if (bnd) begin
            m_pend = 0;
        end
    endtask

    task automatic compare_all();
        check("clk_out",   int'(clk_out),   int'(m_pos >= m_cur + 1));
        check("tick",      int'(tick),      int'(m_tick));
        check("sel_cur",   int'(sel_cur),   m_cur);
        check("done",      int'(done),      int'(m_ack));
        check("sel_ready", int'(sel_ready), int'(!m_pend && !m_ack));
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        compare_all();
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n   = 1'b1;
        edge_no = 0;
    endtask

    initial begin
        model_reset();
        #12;
        compare_all();                 // reset values
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;

        // Default rate /6: ticks at edges 3, 9, 15.
        for (int e = 1; e <= 16; e++) begin
            step();
            if (e == 3 || e == 9 || e == 15)
                check("tick_at_edge", int'(tick), 1);
        end

        // Move to /2, then request /8 at an arbitrary point.
        sel_valid = 1'b1; sel_in = 2'b00;
        step();
        sel_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        sel_valid = 1'b1; sel_in = 2'b11;
        step();
        sel_valid = 1'b0;
        for (int i = 0; i < 24; i++) step();

        // In /8, request /2 right after a clk_out rise: full high phase first.
        for (int i = 0; i < 20 && !m_tick; i++) step();
        check("saw_tick_in_div8", int'(m_tick), 1);
        sel_valid = 1'b1; sel_in = 2'b00;
        step();
        sel_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();

        // Continuous sel_valid with sel_in toggling every cycle.
        sel_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            sel_in = (i % 2 == 0) ? 2'b01 : 2'b10;
            step();
        end
        sel_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // run dropped while a /8 request waits.
        sel_valid = 1'b1; sel_in = 2'b11;
        step();
        sel_valid = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 4; i++) step();
        run = 1'b1;
        for (int i = 0; i < 20; i++) step();

        // Reset while a request is pending.
        sel_valid = 1'b1; sel_in = 2'b00;
        step();
        sel_valid = 1'b0;
        check("pending_before_reset", int'(sel_ready), 0);
        async_reset();
        for (int i = 0; i < 10; i++) step();

        // Randomized traffic with occasional run drops and resets.
        for (int i = 0; i < 3000; i++) begin
            run       = ($urandom_range(15) != 0);
            sel_valid = ($urandom_range(3) == 0);
            sel_in    = 2'($urandom_range(3));
            step();
            if ($urandom_range(399) == 0)
                async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
